rl_digit_serial_mult: RTL



---
 rtl/rl_digit_serial_mult.sv | 109 ++++++++++
 1 files changed

// File: rtl/rl_digit_serial_mult.sv
// Digit-serial multiplier: one DIGIT-bit slice of b per cycle, valid/ready on both sides.
// Optional two's-complement mode enabled by defining RL_MULT_SIGNED_EN.
module rl_digit_serial_mult #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);
  localparam int NSTEP = WIDTH / DIGIT;
  localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0]   areg, breg;
  logic [WIDTH-1:0]   a_ld, b_ld;
  logic [2*WIDTH-1:0] acc, acc_nxt, pp, p_fin;
  logic [CW-1:0]      cnt;
  logic [DIGIT-1:0]   dig;
  logic               last;

  assign last    = (cnt == CW'(NSTEP-1));
  assign dig     = breg[DIGIT*cnt +: DIGIT];
  // partial product is zero-extended to full width before the digit shift
  assign pp      = ((2*WIDTH)'(areg) * (2*WIDTH)'(dig)) << (DIGIT*cnt);
  assign acc_nxt = acc + pp;

`ifdef RL_MULT_SIGNED_EN
  logic sign;
  // magnitude of the most negative value wraps to 2^(WIDTH-1), read as unsigned
  assign a_ld  = a[WIDTH-1] ? -a : a;
  assign b_ld  = b[WIDTH-1] ? -b : b;
  assign p_fin = sign ? -acc_nxt : acc_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n)
      sign <= 1'b0;
    else if (state == IDLE && in_valid)
      sign <= a[WIDTH-1] ^ b[WIDTH-1];
  end
`else
  assign a_ld  = a;
  assign b_ld  = b;
  assign p_fin = acc_nxt;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // handshake outputs decode from state only
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      areg <= '0;
      breg <= '0;
      acc  <= '0;
      cnt  <= '0;
      p    <= '0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          areg <= a_ld;
          breg <= b_ld;
          acc  <= '0;
          cnt  <= '0;
        end
        RUN: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
          if (last) p <= p_fin;
        end
        default: ;
      endcase
    end
  end
endmodule
